// File: rtl/fifo_user_if.sv
// Queue-side bundle: push/pop handshake plus data for one fifo instance.
// Handshake: a push happens on a rising edge when write_valid && write_ready,
// and a pop when read_valid && read_ready. Each ready is the fifo's own status.
interface fifo_if #(
  parameter int WIDTH = 32
);
  logic             write_valid;
  logic             write_ready;
  logic [WIDTH-1:0] in_data;
  logic             read_valid;
  logic             read_ready;
  logic [WIDTH-1:0] out_data;

  // master: the agent pushing into / popping from the queue
  modport master (
    output write_valid, in_data, read_valid,
    input  write_ready, read_ready, out_data
  );

  // slave: the queue itself
  modport slave (
    input  write_valid, in_data, read_valid,
    output write_ready, read_ready, out_data
  );
endinterface

// File: rtl/fifo_user.sv
// First-word fall-through fifo plus a small sequencer that pushes one constant
// word into an output queue, then raises a sticky done flag.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_valid,
  output logic             write_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             read_valid,
  output logic             read_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign write_ready = (count != CW'(DEPTH));
  assign read_ready  = (count != '0);
  assign do_push     = write_valid && write_ready;
  assign do_pop      = read_valid && read_ready;
  assign out_data    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is never cleared; reset only blocks a write in the same edge.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= in_data;
  end
endmodule

module fifo_user #(
  parameter logic [31:0] WRITE_VALUE = 32'h0000_002A
) (
  input  logic        clk,
  input  logic        rst,
  output logic        valid,
  output logic        fifo_1_write_valid,
  output logic [31:0] fifo_1_in_data
);
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= S0;
    else     state <= state_next;
  end

  // Unconditional one-step-per-clock walk; S5 holds until reset.
  always_comb begin
    state_next = state;
    case (state)
      S0:      state_next = S1;
      S1:      state_next = S2;
      S2:      state_next = S3;
      S3:      state_next = S4;
      S4:      state_next = S5;
      S5:      state_next = S5;
      default: state_next = S0;
    endcase
  end

  always_comb begin
    valid              = (state == S5);
    fifo_1_write_valid = (state == S3);
    fifo_1_in_data     = WRITE_VALUE;
  end
endmodule

// File: tb/tb_fifo_user.sv
// Directed bench: sequencer driving a 32x16 output queue, plus a standalone
// input queue exercised for fill, overflow, wrap and reset behaviour.
module tb_fifo_user;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic user_valid;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_if #(.WIDTH(32)) q_out ();
  fifo_if #(.WIDTH(32)) q_in ();

  fifo_user u_user (
    .clk(clk), .rst(rst), .valid(user_valid),
    .fifo_1_write_valid(q_out.write_valid), .fifo_1_in_data(q_out.in_data)
  );

  fifo #(.WIDTH(32), .DEPTH(16)) u_out (
    .clk(clk), .rst(rst),
    .write_valid(q_out.write_valid), .write_ready(q_out.write_ready),
    .in_data(q_out.in_data), .read_valid(q_out.read_valid),
    .read_ready(q_out.read_ready), .out_data(q_out.out_data)
  );

  fifo #(.WIDTH(32), .DEPTH(16)) u_in (
    .clk(clk), .rst(rst),
    .write_valid(q_in.write_valid), .write_ready(q_in.write_ready),
    .in_data(q_in.in_data), .read_valid(q_in.read_valid),
    .read_ready(q_in.read_ready), .out_data(q_in.out_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Six free edges after a reset edge: write strobe in S3, push lands at
  // edge 4, done flag from edge 5 on.
  task automatic run_timing(input string tag);
    logic [5:0] exp_wv;
    logic [5:0] exp_vld;
    logic [5:0] exp_rr;
    exp_wv  = 6'b000100;
    exp_vld = 6'b110000;
    exp_rr  = 6'b111000;
    for (int e = 0; e < 6; e++) begin
      step();
      check($sformatf("%s_wv_e%0d", tag, e + 1), {31'd0, q_out.write_valid}, {31'd0, exp_wv[e]});
      check($sformatf("%s_valid_e%0d", tag, e + 1), {31'd0, user_valid}, {31'd0, exp_vld[e]});
      check($sformatf("%s_rr_e%0d", tag, e + 1), {31'd0, q_out.read_ready}, {31'd0, exp_rr[e]});
    end
    check({tag, "_out_data"}, q_out.out_data, 32'h2A);
    check({tag, "_wr"}, {31'd0, q_out.write_ready}, 32'd1);
  endtask

  initial begin
    q_out.read_valid = 1'b0;
    q_in.write_valid = 1'b0;
    q_in.read_valid  = 1'b0;
    q_in.in_data     = '0;

    // Reset edge: S0 outputs
    rst = 1'b1;
    step();
    check("rst_valid", {31'd0, user_valid}, 32'd0);
    check("rst_wv", {31'd0, q_out.write_valid}, 32'd0);
    check("rst_in_wr", {31'd0, q_in.write_ready}, 32'd1);
    check("rst_in_rr", {31'd0, q_in.read_ready}, 32'd0);
    rst = 1'b0;
    run_timing("run1");

    // Single push / pop on the input queue
    q_in.write_valid = 1'b1;
    q_in.in_data     = 32'd791;
    step();
    q_in.write_valid = 1'b0;
    check("one_rr", {31'd0, q_in.read_ready}, 32'd1);
    check("one_wr", {31'd0, q_in.write_ready}, 32'd1);
    check("one_data", q_in.out_data, 32'd791);
    q_in.read_valid = 1'b1;
    step();
    q_in.read_valid = 1'b0;
    check("one_pop_rr", {31'd0, q_in.read_ready}, 32'd0);

    // Fill to 16, overflow ignored, drain in order
    for (int i = 0; i < 16; i++) begin
      q_in.write_valid = 1'b1;
      q_in.in_data     = i;
      step();
    end
    check("full_wr", {31'd0, q_in.write_ready}, 32'd0);
    q_in.in_data = 32'd999;
    step();
    q_in.write_valid = 1'b0;
    check("ovf_wr", {31'd0, q_in.write_ready}, 32'd0);
    check("ovf_head", q_in.out_data, 32'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), q_in.out_data, i);
      q_in.read_valid = 1'b1;
      step();
    end
    q_in.read_valid = 1'b0;
    check("drain_empty", {31'd0, q_in.read_ready}, 32'd0);
    check("drain_wr", {31'd0, q_in.write_ready}, 32'd1);

    // Occupancy 8, then simultaneous push/pop across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      q_in.write_valid = 1'b1;
      q_in.in_data     = 100 + i;
      exp_q.push_back(100 + i);
      step();
    end
    for (int k = 0; k < 12; k++) begin
      check($sformatf("pp_head_%0d", k), q_in.out_data, exp_q.pop_front());
      q_in.write_valid = 1'b1;
      q_in.read_valid  = 1'b1;
      q_in.in_data     = 200 + k;
      exp_q.push_back(200 + k);
      step();
      check($sformatf("pp_rr_%0d", k), {31'd0, q_in.read_ready}, 32'd1);
      check($sformatf("pp_wr_%0d", k), {31'd0, q_in.write_ready}, 32'd1);
    end
    q_in.write_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("pp_drain_%0d", k), q_in.out_data, exp_q.pop_front());
      q_in.read_valid = 1'b1;
      step();
    end
    q_in.read_valid = 1'b0;
    check("pp_count8_empty", {31'd0, q_in.read_ready}, 32'd0);

    // Reset while sequencer is in S4 with data in both queues
    rst = 1'b1;
    step();
    rst = 1'b0;
    q_in.write_valid = 1'b1;
    q_in.in_data     = 32'd55;
    for (int e = 0; e < 4; e++) step();
    q_in.write_valid = 1'b0;
    check("s4_valid", {31'd0, user_valid}, 32'd0);
    check("s4_out_rr", {31'd0, q_out.read_ready}, 32'd1);
    check("s4_in_rr", {31'd0, q_in.read_ready}, 32'd1);
    rst = 1'b1;
    q_in.write_valid = 1'bx;
    q_in.read_valid  = 1'bx;
    step();
    check("mid_rst_valid", {31'd0, user_valid}, 32'd0);
    check("mid_rst_wv", {31'd0, q_out.write_valid}, 32'd0);
    check("mid_rst_out_rr", {31'd0, q_out.read_ready}, 32'd0);
    check("mid_rst_in_rr", {31'd0, q_in.read_ready}, 32'd0);
    check("mid_rst_in_wr", {31'd0, q_in.write_ready}, 32'd1);
    q_in.write_valid = 1'b0;
    q_in.read_valid  = 1'b0;
    rst = 1'b0;
    run_timing("run2");
    check("run2_in_rr", {31'd0, q_in.read_ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
